top: RTL and testbench
======================

# top

Synchronous AXI-Stream FIFO buffer that sits between an upstream packet source and a downstream consumer. It accepts beats of 16-bit data with a 5-bit keep field and a last flag, stores them in order, and replays them unchanged on its master interface. It decouples backpressure between the two sides and sustains one beat per clock.

## Interface
- DATA_W, 16, width of tdata.
- KEEP_W, 5, width of tkeep; opaque sideband that is stored and forwarded and never interpreted.
- DEPTH, 16, number of storage entries; must be a power of two and ≥2.
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  reset. One clock; reset is synchronous and active-high. The port name is historical: reset is asserted while reset_n=1, sampled on the rising edge of clk.
- input_tdata  in  DATA_W  slave data.
- input_tvalid  in  1  slave valid.
- input_tkeep  in  KEEP_W  slave keep, stored verbatim.
- input_tlast  in  1  slave end-of-packet.
- input_tready  out  1  slave ready.
- output_tdata  out  DATA_W  master data.
- output_tvalid  out  1  master valid.
- output_tkeep  out  KEEP_W  master keep.
- output_tlast  out  1  master end-of-packet.
- output_tready  in  1  master ready.

## Operation
- Storage: DEPTH entries of {tlast, tkeep, tdata} (22 bits by default), write pointer, read pointer (log2 DEPTH bits each, wrapping modulo DEPTH), occupancy count 0..DEPTH.
- Write: occurs when input_tvalid & input_tready at a clock edge. Stores the beat at the write pointer, then increments the write pointer.
- Read: occurs when output_tvalid & output_tready at a clock edge. Increments the read pointer.
- count update:
  - +1 on write only.
  - −1 on read only.
  - unchanged on simultaneous read and write, or on neither.
- input_tready = (count != DEPTH) and reset not asserted. Combinational from registers and reset only; never depends on input_tvalid.
- output_tvalid = (count != 0).
- output_tdata, output_tkeep and output_tlast = entry at the read pointer (first-word fall-through). Held stable while output_tvalid=1 and output_tready=0.
- Full (count=DEPTH): input_tready=0. A read in the same cycle does not enable a write in that cycle; ready rises the cycle after.
- Empty (count=0): output_tvalid=0. There is no combinational bypass, so a write into an empty FIFO appears on the output the next cycle.
- Beats, tkeep values (including 0) and tlast are forwarded in order and bit-exact. Packets are not reassembled, padded or split.
- The source may drop input_tvalid at any cycle. Bubbles are tolerated with no loss and no duplication.

## Timing
- Reset (synchronous, while asserted):
  - pointers and count cleared to 0.
  - all storage entries cleared to 0.
  - input_tready=0, output_tvalid=0, output_tdata=0, output_tkeep=0, output_tlast=0.
- First cycle after deassertion: input_tready=1.
- Latency: a beat accepted at edge N is presented on the outputs with output_tvalid=1 after edge N.
- Throughput: with output_tready held at 1 and continuous input, one beat per cycle. count settles at 1 and input_tready stays 1.
- Reset mid-operation: stored beats are discarded and outputs return to reset values at the next edge. A beat offered in the reset cycle is not accepted.
- Pointer wrap from DEPTH−1 to 0 is seamless and needs no idle cycle.

## Test plan
- Reset: hold reset 3 cycles → input_tready=0, output_tvalid=0 and all output data fields 0 throughout. After release, input_tready=1.
- Streaming:
  - Stimulus: 11 consecutive beats, tdata 0x0001..0x000B, tkeep=2, tlast=1 on beat 11, output_tready=1.
  - Response: identical 11 beats appear one cycle after each is accepted, in order, with tlast only on 0x000B.
- Fill to full:
  - Stimulus: output_tready=0 and 17 beats offered.
  - Response: exactly 16 accepted. input_tready=0 after the 16th. output_tdata holds 0x0001 stable.
- Drain from full:
  - Stimulus: raise output_tready with input still valid.
  - Response: input_tready returns to 1 one cycle after the first read. Output order continues 0x0001..0x0010, then 0x0011.
- Wrap and bubbles:
  - Stimulus: 40 beats with random input_tvalid and random output_tready gaps.
  - Response: the scoreboard matches every beat, tkeep and tlast exactly. No drops, no duplicates.
- Mid-stream reset:
  - Stimulus: reset asserted with 5 beats stored.
  - Response: output_tvalid=0 next cycle and the 5 beats are never emitted. The next packet after release passes intact.

Source files
------------

// File: rtl/top.sv
// AXI-Stream FIFO: DEPTH entries of {tlast, tkeep, tdata}, first-word
// fall-through, one beat per clock, full backpressure decoupling.
// reset_n is active-high (historical name) and synchronous.
module top #(
    parameter int DATA_W = 16,
    parameter int KEEP_W = 5,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] input_tdata,
    input  logic              input_tvalid,
    input  logic [KEEP_W-1:0] input_tkeep,
    input  logic              input_tlast,
    output logic              input_tready,
    output logic [DATA_W-1:0] output_tdata,
    output logic              output_tvalid,
    output logic [KEEP_W-1:0] output_tkeep,
    output logic              output_tlast,
    input  logic              output_tready
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + KEEP_W + DATA_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               wr_en;
    logic               rd_en;

    // Ready only reflects stored occupancy and reset, so a read in a full
    // cycle cannot open the input until the following cycle.
    assign input_tready  = (count_q != CNT_W'(DEPTH)) && !reset_n;
    assign output_tvalid = (count_q != '0);
    assign {output_tlast, output_tkeep, output_tdata} = mem_q[rd_ptr_q];

    assign wr_en = input_tvalid && input_tready;
    assign rd_en = output_tvalid && output_tready;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = {input_tlast, input_tkeep, input_tdata};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // State registers; reset clears every entry so outputs read back zero.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_top.sv
// Bench for the AXI-Stream FIFO: a queue model tracks stored beats and
// predicts ready/valid/data every cycle.
module tb_top;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] input_tdata;
    logic        input_tvalid;
    logic [4:0]  input_tkeep;
    logic        input_tlast;
    logic        input_tready;
    logic [15:0] output_tdata;
    logic        output_tvalid;
    logic [4:0]  output_tkeep;
    logic        output_tlast;
    logic        output_tready;

    top dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .input_tdata  (input_tdata),
        .input_tvalid (input_tvalid),
        .input_tkeep  (input_tkeep),
        .input_tlast  (input_tlast),
        .input_tready (input_tready),
        .output_tdata (output_tdata),
        .output_tvalid(output_tvalid),
        .output_tkeep (output_tkeep),
        .output_tlast (output_tlast),
        .output_tready(output_tready)
    );

    always #5 clk = ~clk;

    logic [21:0] mq[$];
    int n_cmp = 0;
    int n_bad = 0;
    int dut_push = 0;
    int dut_pop = 0;
    logic rst_seen = 1'b0;
    logic last_wr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check against model, update model at posedge.
    task automatic step(input logic r, input logic v, input logic [15:0] d,
                        input logic [4:0] k, input logic l, input logic ordy);
        logic m_rdy, m_vld, wr, rd;
        reset_n       = r;
        input_tvalid  = v;
        input_tdata   = d;
        input_tkeep   = k;
        input_tlast   = l;
        output_tready = ordy;
        #1;
        m_rdy = !r && (mq.size() != 16);
        m_vld = (mq.size() != 0);
        check("tready", 32'(input_tready), 32'(m_rdy));
        check("tvalid", 32'(output_tvalid), 32'(m_vld));
        if (m_vld)
            check("beat", 32'({output_tlast, output_tkeep, output_tdata}), 32'(mq[0]));
        else if (rst_seen)
            check("zero", 32'({output_tlast, output_tkeep, output_tdata}), 32'd0);
        if (input_tvalid && input_tready) dut_push++;
        if (output_tvalid && output_tready) dut_pop++;
        wr = v && m_rdy;
        rd = m_vld && ordy;
        last_wr = wr;
        @(posedge clk);
        if (r) begin
            mq.delete();
        end else begin
            if (rd) void'(mq.pop_front());
            if (wr) mq.push_back({l, k, d});
        end
        rst_seen = r;
        @(negedge clk);
    endtask

    initial begin
        int pops0, push0, idx, acc;
        logic [15:0] d;
        reset_n = 1'b1; input_tvalid = 1'b0; input_tdata = '0;
        input_tkeep = '0; input_tlast = 1'b0; output_tready = 1'b0;
        @(posedge clk);
        rst_seen = 1'b1;
        @(negedge clk);

        // Reset held, beat offered and ignored.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'hAAAA, 5'h1F, 1'b1, 1'b1);

        // Streaming 11 beats.
        pops0 = dut_pop;
        for (int i = 1; i <= 11; i++) step(1'b0, 1'b1, 16'(i), 5'd2, (i == 11), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
        check("stream_pops", 32'(dut_pop - pops0), 32'd11);

        // Fill to full with 17 offers.
        push0 = dut_push;
        idx = 1;
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b1, 16'(idx), 5'(idx), idx[0], 1'b0);
            if (last_wr) idx++;
        end
        check("fill_accepts", 32'(dut_push - push0), 32'd16);
        check("fill_head", 32'(output_tdata), 32'h0001);

        // Drain from full while still offering beats 0x11..0x14.
        while (idx <= 20) begin
            step(1'b0, 1'b1, 16'(idx), 5'(idx), idx[0], 1'b1);
            if (last_wr) idx++;
            if (dut_push - push0 > 40) break;
        end
        for (int i = 0; i < 24 && mq.size() != 0; i++)
            step(1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
        check("fill_total", 32'(dut_push - push0), 32'd20);

        // Random bubbles and backpressure with wrap.
        pops0 = dut_pop;
        acc = 0;
        d = 16'($urandom);
        for (int i = 0; i < 600 && acc < 40; i++) begin
            step(1'b0, 1'($urandom_range(0, 2) != 0), d, 5'($urandom), 1'($urandom),
                 1'($urandom_range(0, 2) == 0));
            if (last_wr) begin
                acc++;
                d = 16'($urandom);
            end
        end
        check("rand_accepts", 32'(acc), 32'd40);
        for (int i = 0; i < 40 && mq.size() != 0; i++)
            step(1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'($urandom));
        for (int i = 0; i < 20 && mq.size() != 0; i++)
            step(1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
        check("rand_pops", 32'(dut_pop - pops0), 32'd40);

        // Mid-stream reset with 5 beats stored.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h100 + 16'(i), 5'd7, 1'b0, 1'b0);
        check("mid_tvalid_pre", 32'(output_tvalid), 32'd1);
        pops0 = dut_pop;
        step(1'b1, 1'b1, 16'hDEAD, 5'd3, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'hBEEF, 5'd3, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h200 + 16'(i), 5'd0, (i == 3), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
        check("mid_pops", 32'(dut_pop - pops0), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
